blockram_true_dual_port: RTL and testbench

//  Synchronous true dual-port block RAM with two independent read/write ports (A, B) sharing one storage array and one clock.

---
 rtl/blockram_pkg.sv | 17 +
 rtl/blockram_port_out.sv | 50 +++++
 rtl/blockram_true_dual_port.sv | 81 ++++++++
 tb/tb_blockram_true_dual_port.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/blockram_pkg.sv
// Shared definitions for the true dual-port block RAM: default geometry,
// address-width helper and the read-mode enumeration.
package blockram_pkg;

    localparam int DEFAULT_RAM_WIDTH = 16;
    localparam int DEFAULT_RAM_DEPTH = 1024;

    // Only read-first is implemented: a read colliding with a write returns old data.
    typedef enum logic [0:0] {
        READ_FIRST = 1'b0
    } read_mode_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/blockram_port_out.sv
// Per-port read data register; with BLOCKRAM_OUTPUT_REG_EN defined an extra
// free-running output stage is added, giving two cycles of read latency.
module blockram_port_out
    import blockram_pkg::*;
#(
    parameter int WIDTH = DEFAULT_RAM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage1_d;

    // An unknown enable compares as not-true, so it is treated as inactive.
    always_comb begin
        stage1_d = stage1_q;
        if (rd_en_i == 1'b1) begin
            stage1_d = rd_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
        end else begin
            stage1_q <= stage1_d;
        end
    end

`ifdef BLOCKRAM_OUTPUT_REG_EN
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage2_q <= '0;
        end else begin
            stage2_q <= stage1_q;
        end
    end

    assign data_o = stage2_q;
`else
    assign data_o = stage1_q;
`endif

endmodule

// File: rtl/blockram_true_dual_port.sv
// True dual-port, read-first block RAM with A-over-B write arbitration.
// Optional macro BLOCKRAM_OUTPUT_REG_EN adds an output pipeline stage per port.
module blockram_true_dual_port
    import blockram_pkg::*;
#(
    parameter int RAM_WIDTH = DEFAULT_RAM_WIDTH,
    parameter int RAM_DEPTH = DEFAULT_RAM_DEPTH,
    localparam int ADDR_W   = addr_w(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_enable_A,
    input  logic                 read_enable_A,
    input  logic [ADDR_W-1:0]    address_A,
    input  logic [RAM_WIDTH-1:0] data_in_A,
    output logic [RAM_WIDTH-1:0] data_out_A,
    input  logic                 write_enable_B,
    input  logic                 read_enable_B,
    input  logic [ADDR_W-1:0]    address_B,
    input  logic [RAM_WIDTH-1:0] data_in_B,
    output logic [RAM_WIDTH-1:0] data_out_B
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

    logic                 in_range_a;
    logic                 in_range_b;
    logic                 wr_a;
    logic                 wr_b;
    logic [RAM_WIDTH-1:0] rd_data_a;
    logic [RAM_WIDTH-1:0] rd_data_b;

    // Always true for power-of-two depths; guards the tail of odd-sized arrays.
    assign in_range_a = ({1'b0, address_A} < DEPTH_EXT);
    assign in_range_b = ({1'b0, address_B} < DEPTH_EXT);

    assign wr_a = (write_enable_A == 1'b1) && in_range_a;
    assign wr_b = (write_enable_B == 1'b1) && in_range_b;

    // Writes are suppressed while reset is held; B is written first so that a
    // same-address write from A overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else begin
            if (wr_b) begin
                mem[address_B] <= data_in_B;
            end
            if (wr_a) begin
                mem[address_A] <= data_in_A;
            end
        end
    end

    // Read data is sampled by the output registers at the same edge as any
    // write, so colliding reads see the pre-write contents.
    assign rd_data_a = in_range_a ? mem[address_A] : '0;
    assign rd_data_b = in_range_b ? mem[address_B] : '0;

    blockram_port_out #(
        .WIDTH(RAM_WIDTH)
    ) u_port_out_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en_i  (read_enable_A),
        .rd_data_i(rd_data_a),
        .data_o   (data_out_A)
    );

    blockram_port_out #(
        .WIDTH(RAM_WIDTH)
    ) u_port_out_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en_i  (read_enable_B),
        .rd_data_i(rd_data_b),
        .data_o   (data_out_B)
    );

endmodule

// File: tb/tb_blockram_true_dual_port.sv
// Randomised and directed bench for blockram_true_dual_port against a
// word-array reference model of the RAM and its read latency.
module tb_blockram_true_dual_port;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int AW = 10;
`ifdef BLOCKRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          write_enable_A;
    logic          read_enable_A;
    logic [AW-1:0] address_A;
    logic [W-1:0]  data_in_A;
    logic [W-1:0]  data_out_A;
    logic          write_enable_B;
    logic          read_enable_B;
    logic [AW-1:0] address_B;
    logic [W-1:0]  data_in_B;
    logic [W-1:0]  data_out_B;

    blockram_true_dual_port #(
        .RAM_WIDTH(W),
        .RAM_DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_enable_A(write_enable_A),
        .read_enable_A (read_enable_A),
        .address_A     (address_A),
        .data_in_A     (data_in_A),
        .data_out_A    (data_out_A),
        .write_enable_B(write_enable_B),
        .read_enable_B (read_enable_B),
        .address_B     (address_B),
        .data_in_B     (data_in_B),
        .data_out_B    (data_out_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus the last value each port has read.
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] held_a;
    logic [W-1:0] held_b;
    int checks;
    int errors;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_cycle(input string tag,
                            input logic wa, input logic ra, input logic [AW-1:0] aa, input logic [W-1:0] da,
                            input logic wb, input logic rb, input logic [AW-1:0] ab, input logic [W-1:0] db);
        logic [W-1:0] prev_a;
        logic [W-1:0] prev_b;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        write_enable_A = wa;
        read_enable_A  = ra;
        address_A      = aa;
        data_in_A      = da;
        write_enable_B = wb;
        read_enable_B  = rb;
        address_B      = ab;
        data_in_B      = db;
        @(posedge clk);
        prev_a = held_a;
        prev_b = held_b;
        if (ra) held_a = ref_mem[aa];
        if (rb) held_b = ref_mem[ab];
        if (wb) ref_mem[ab] = db;
        if (wa) ref_mem[aa] = da;
        // With the extra output stage the pins show the value read one edge earlier.
        exp_a = (LAT == 2) ? prev_a : held_a;
        exp_b = (LAT == 2) ? prev_b : held_b;
        #1;
        check_val({tag, "_A"}, data_out_A, exp_a);
        check_val({tag, "_B"}, data_out_B, exp_b);
        $display("%s: A we=%0b re=%0b a=%0d d=%h out=%h | B we=%0b re=%0b a=%0d d=%h out=%h",
                 tag, wa, ra, aa, da, data_out_A, wb, rb, ab, db, data_out_B);
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        do_cycle(tag, 1'b0, 1'b0, aa, 16'h0, 1'b0, 1'b0, ab, 16'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        held_a = '0;
        held_b = '0;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        write_enable_A = 1'b0; read_enable_A = 1'b0; address_A = '0; data_in_A = '0;
        write_enable_B = 1'b0; read_enable_B = 1'b0; address_B = '0; data_in_B = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_A", data_out_A, 16'h0000);
        check_val("reset_B", data_out_B, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Parallel writes, then cross reads
        do_cycle("pwrite", 1'b1, 1'b0, 10'd1, 16'hABCD, 1'b1, 1'b0, 10'd2, 16'h1234);
        do_cycle("xread", 1'b0, 1'b1, 10'd2, 16'h0, 1'b0, 1'b1, 10'd1, 16'h0);
        idle("xread_lat", 10'd2, 10'd1);
        check_val("xread_A", data_out_A, 16'h1234);
        check_val("xread_B", data_out_B, 16'hABCD);

        // Hold with enables low and addresses moving
        idle("hold1", 10'd9, 10'd300);
        idle("hold2", 10'd77, 10'd1023);
        check_val("hold_A", data_out_A, 16'h1234);
        check_val("hold_B", data_out_B, 16'hABCD);

        // Same-address write collision: A wins
        do_cycle("collide", 1'b1, 1'b0, 10'd5, 16'h1111, 1'b1, 1'b0, 10'd5, 16'h2222);
        do_cycle("coll_rd", 1'b0, 1'b1, 10'd5, 16'h0, 1'b0, 1'b1, 10'd5, 16'h0);
        idle("coll_lat", 10'd5, 10'd5);
        check_val("collide_A", data_out_A, 16'h1111);
        check_val("collide_B", data_out_B, 16'h1111);

        // Cross-port read-first
        do_cycle("rf_init", 1'b1, 1'b0, 10'd7, 16'h00AA, 1'b0, 1'b0, 10'd0, 16'h0);
        do_cycle("rf_coll", 1'b1, 1'b0, 10'd7, 16'h00BB, 1'b0, 1'b1, 10'd7, 16'h0);
        idle("rf_lat", 10'd7, 10'd7);
        check_val("readfirst_old", data_out_B, 16'h00AA);
        do_cycle("rf_rd2", 1'b0, 1'b0, 10'd7, 16'h0, 1'b0, 1'b1, 10'd7, 16'h0);
        idle("rf_lat2", 10'd7, 10'd7);
        check_val("readfirst_new", data_out_B, 16'h00BB);

        // Same-port read+write: returns old data
        do_cycle("sp_rw", 1'b1, 1'b1, 10'd7, 16'h00CC, 1'b0, 1'b0, 10'd0, 16'h0);
        idle("sp_lat", 10'd7, 10'd0);
        check_val("sameport_old", data_out_A, 16'h00BB);

        // Address boundaries
        do_cycle("bnd_wr", 1'b1, 1'b0, 10'd0, 16'hFFFF, 1'b1, 1'b0, 10'd1023, 16'h0001);
        do_cycle("bnd_rd", 1'b0, 1'b1, 10'd1023, 16'h0, 1'b0, 1'b1, 10'd0, 16'h0);
        idle("bnd_lat", 10'd0, 10'd0);
        check_val("bound_hi", data_out_A, 16'h0001);
        check_val("bound_lo", data_out_B, 16'hFFFF);

        // Asynchronous reset mid-cycle, with a write attempted while held
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_A", data_out_A, 16'h0000);
        check_val("async_rst_B", data_out_B, 16'h0000);
        held_a = '0;
        held_b = '0;
        write_enable_A = 1'b1; address_A = 10'd2; data_in_A = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        write_enable_A = 1'b0;
        rst_n = 1'b1;
        do_cycle("ret_rd", 1'b0, 1'b1, 10'd2, 16'h0, 1'b0, 1'b1, 10'd1, 16'h0);
        idle("ret_lat", 10'd2, 10'd1);
        check_val("retain_A", data_out_A, 16'h1234);
        check_val("retain_B", data_out_B, 16'hABCD);

        // Random traffic, half of it confined to a small window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra_addr;
            logic [AW-1:0] rb_addr;
            if ($urandom_range(0, 1) == 0) begin
                ra_addr = AW'($urandom_range(0, 7));
                rb_addr = AW'($urandom_range(0, 7));
            end else begin
                ra_addr = AW'($urandom_range(0, D - 1));
                rb_addr = AW'($urandom_range(0, D - 1));
            end
            do_cycle("rnd",
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra_addr, W'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb_addr, W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
